// File: rtl/me_pkg.sv
// Shared motion-estimation constants and types for the SAD search datapath.
// PSAD_MIN_SEARCH_ZERO_MV_BIAS_EN consumers use ZERO_MV_IDX / ZMV_BIAS from here.
package me_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int EDGE_LEN        = 8;
    localparam int BIT_DEPTH       = 8;
    localparam int PSAD_BIT_WIDTH  = 11;
    localparam int SAD_BIT_WIDTH   = 14;
    localparam int PIXELS_IN_BATCH = 16;
    localparam int NUM_BATCHES     = 16;
    localparam int IDX_BIT_WIDTH   = 8;
    localparam int ZERO_MV_IDX     = 136;
    localparam int ZMV_BIAS        = 32;

    localparam int LANE_BIT_WIDTH  = clog2(PIXELS_IN_BATCH);
    localparam int BATCH_BIT_WIDTH = clog2(NUM_BATCHES);
    localparam int BEAT_BIT_WIDTH  = PSAD_BIT_WIDTH * EDGE_LEN * PIXELS_IN_BATCH;

    typedef logic [SAD_BIT_WIDTH-1:0]   sad_t;
    typedef logic [IDX_BIT_WIDTH-1:0]   idx_t;
    typedef logic [LANE_BIT_WIDTH-1:0]  lane_t;
    typedef logic [BATCH_BIT_WIDTH-1:0] batch_t;

endpackage

// File: rtl/sad_lane_min.sv
// Combinational minimum over the per-lane SADs of one batch; the lowest lane
// index wins a tie because only a strictly smaller value displaces the holder.
module sad_lane_min
    import me_pkg::*;
(
    input  sad_t  i_sads [PIXELS_IN_BATCH],
    output sad_t  o_min_sad,
    output lane_t o_min_lane
);

    always_comb begin
        o_min_sad  = i_sads[0];
        o_min_lane = '0;
        for (int l = 1; l < PIXELS_IN_BATCH; l++) begin
            if (i_sads[l] < o_min_sad) begin
                o_min_sad  = i_sads[l];
                o_min_lane = lane_t'(l);
            end
        end
    end

endmodule

// File: rtl/psad_min_search.sv
// Sums partial SADs per candidate and tracks the best candidate of a search
// through a three-stage pipeline. Optional: PSAD_MIN_SEARCH_ZERO_MV_BIAS_EN.
module psad_min_search
    import me_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      psad_valid_i,
    input  logic [BEAT_BIT_WIDTH-1:0] psad_addend_batch_i,
    output logic                      busy_o,
    output logic [SAD_BIT_WIDTH-1:0]  best_sad_o,
    output logic [IDX_BIT_WIDTH-1:0]  best_idx_o,
    output logic                      done_o
);

    // Handshake: a beat transfers on any rising edge where psad_valid_i and
    // busy_o are both high and start_i is low; there is no backpressure.

    logic   r_busy;
    batch_t r_cnt;
    logic   r_s1_valid;
    batch_t r_s1_batch;
    sad_t   r_s1_sad [PIXELS_IN_BATCH];
    logic   r_s2_valid;
    batch_t r_s2_batch;
    sad_t   r_s2_sad;
    lane_t  r_s2_lane;
    sad_t   r_best_sad;
    idx_t   r_best_idx;
    logic   r_done;

    logic   w_accept;
    logic   w_last_beat;
    sad_t   w_lane_sad [PIXELS_IN_BATCH];
    sad_t   w_min_sad;
    lane_t  w_min_lane;
    idx_t   w_s2_idx;

    assign w_accept    = psad_valid_i & r_busy;
    assign w_last_beat = (r_cnt == batch_t'(NUM_BATCHES - 1));
    assign w_s2_idx    = idx_t'(r_s2_batch) * idx_t'(PIXELS_IN_BATCH) + idx_t'(r_s2_lane);

    always_comb begin
        for (int p = 0; p < PIXELS_IN_BATCH; p++) begin
            w_lane_sad[p] = '0;
            for (int r = 0; r < EDGE_LEN; r++) begin
                w_lane_sad[p] = w_lane_sad[p]
                    + sad_t'(psad_addend_batch_i[(p*EDGE_LEN+r)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
            end
`ifdef PSAD_MIN_SEARCH_ZERO_MV_BIAS_EN
            // Credit the zero-motion candidate so static content prefers no motion.
            if (r_cnt == batch_t'(ZERO_MV_IDX / PIXELS_IN_BATCH) &&
                p == ZERO_MV_IDX % PIXELS_IN_BATCH) begin
                w_lane_sad[p] = (w_lane_sad[p] > sad_t'(ZMV_BIAS))
                              ? w_lane_sad[p] - sad_t'(ZMV_BIAS) : '0;
            end
`endif
        end
    end

    sad_lane_min u_lane_min (
        .i_sads     (r_s1_sad),
        .o_min_sad  (w_min_sad),
        .o_min_lane (w_min_lane)
    );

    // Control and result state; data-only pipeline registers live below.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_best_sad <= '1;
            r_best_idx <= '0;
            r_done     <= 1'b0;
        end else if (start_i) begin
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_best_sad <= '1;
            r_best_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_done     <= r_s2_valid && (r_s2_batch == batch_t'(NUM_BATCHES - 1));
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last_beat) begin
                    r_busy <= 1'b0;
                end
            end
            // Strictly-less keeps the earlier batch on ties.
            if (r_s2_valid && (r_s2_sad < r_best_sad)) begin
                r_best_sad <= r_s2_sad;
                r_best_idx <= w_s2_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s1_sad   <= w_lane_sad;
            r_s1_batch <= r_cnt;
        end
        if (r_s1_valid) begin
            r_s2_sad   <= w_min_sad;
            r_s2_lane  <= w_min_lane;
            r_s2_batch <= r_s1_batch;
        end
    end

    assign busy_o     = r_busy;
    assign best_sad_o = r_best_sad;
    assign best_idx_o = r_best_idx;
    assign done_o     = r_done;

endmodule
